ysyx_22050133_divider: RTL and testbench
========================================

Name: ysyx_22050133_divider

Overview:
Iterative radix-2 restoring integer divider. It is the inverse companion to the team's Booth multiplier and shares the same valid/ready/flush/out_valid handshake with the EXU. It implements RV64M DIV/DIVU/REM/REMU and the W variants (DIVW/DIVUW/REMW/REMUW), producing both quotient and remainder per operation. Divide-by-zero and signed overflow are resolved by a short special-case path.

Parameters:
XLEN, 64, operand/result width; the W variants use the low XLEN/2 bits.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  abort the current division and discard it (from pipeline flush)
div_valid  in  1  request valid; deassert the cycle after acceptance unless a new op follows
divw  in  1  1 = 32-bit op (W variant)
div_signed  in  1  1 = signed (DIV/REM), 0 = unsigned
dividend  in  XLEN  dividend
divisor  in  XLEN  divisor
div_ready  out  1  divider can accept a request
out_valid  out  1  quotient/remainder valid; single-cycle pulse
quotient  out  XLEN  quotient result
remainder  out  XLEN  remainder result

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - out_valid, quotient, remainder and all internal registers = 0.
  - div_ready = 1 from the first cycle after release.
- States:
  - IDLE: div_ready = 1. div_valid & div_ready & ~flush -> latch operands, go to BUSY with count = 0.
  - BUSY: div_ready = 0. Performs one iteration per cycle.
- Operand prep at accept:
  - W op: use bits [31:0], sign- or zero-extended per div_signed; N = 32. Otherwise N = 64.
  - Signed: take absolute values and record sign_q = sa ^ sb and sign_r = sa.
- Iteration (per BUSY cycle):
  - Shift partial remainder left 1 and bring in the next dividend bit.
  - Trial-subtract |divisor|. If non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - count increments.
- Completion, on the edge ending BUSY cycle N:
  - Negate quotient if sign_q; negate remainder if sign_r.
  - W op: sign-extend both results from bit 31 (this applies to DIVUW/REMUW too).
  - Register quotient/remainder, out_valid <= 1, state <= IDLE.
- Special cases, detected at accept. Each takes 1 BUSY cycle, then completes:
  - Divisor == 0 (on the effective width): quotient = all ones (W: sign-extended 0xFFFF_FFFF), remainder = dividend (W: sign-extended low 32 bits).
  - Signed overflow (most-negative / -1 at the effective width): quotient = dividend (W: sign-extended), remainder = 0.
- Latency, counting the accept cycle as cycle 0:
  - out_valid high in cycle 65 (64-bit op), cycle 33 (W op), cycle 2 (special case).
- out_valid is high exactly one cycle. div_ready is 1 in that same cycle, so back-to-back accepts are allowed.
- quotient/remainder hold their values until the next completion.
- Flush:
  - Sampled high in BUSY: next edge -> IDLE, no out_valid, and quotient/remainder unchanged.
  - High in IDLE together with div_valid: the request is not accepted.
  - High in the out_valid cycle: no effect on the already-completed result.
- Reset asserted mid-operation: immediate return to reset values. The aborted op never produces out_valid.

Decomposition:
- Shared package:
  - XLEN.
  - State encodings DIV_IDLE and DIV_BUSY.
  - Constants for the 32-bit and 64-bit iteration counts.
- Sub-module ysyx_22050133_div_step: combinational single restoring step. Inputs are partial remainder, dividend bit and |divisor|; outputs are the next remainder and the quotient bit. The top level owns the FSM, counter, sign fix-up and special cases.

Test Plan:
1. 64-bit signed: -7 / 2 -> quotient 0xFFFF_FFFF_FFFF_FFFD, remainder 0xFFFF_FFFF_FFFF_FFFF; out_valid in cycle 65 only; div_ready 0 in cycles 1-64.
2. Unsigned 64-bit: 100 / 0 -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 100; out_valid in cycle 2.
3. Signed 64-bit: 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0; out_valid in cycle 2.
4. W ops:
   - DIVUW: 0x1234_5678_FFFF_FFFF / 1 -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 0, cycle 33.
   - DIVW: 0x8000_0000 / 0xFFFF_FFFF -> quotient 0xFFFF_FFFF_8000_0000, remainder 0, cycle 2.
5. Flush in cycle 10 of a 64-bit op -> no out_valid. div_ready 1 the next cycle. A following unsigned 9 / 3 yields quotient 3, remainder 0 at cycle 65 of that op.
6. Two back-to-back ops:
   - 20 / 6 accepted in the out_valid cycle of 7 / 2 -> results 3/1, then 3/2.
   - rst pulled low mid-op -> out_valid, quotient and remainder read 0 immediately; div_ready 1 after release.

Source files
------------

// File: rtl/ysyx_22050133_divider_pkg.sv
// Shared definitions for the radix-2 restoring divider: width, FSM states,
// iteration counts and the 32-to-XLEN sign-extension helper.
package ysyx_22050133_divider_pkg;

  localparam int XLEN    = 64;
  localparam int CNT_W   = 6;
  localparam int ITER_32 = 32;
  localparam int ITER_64 = 64;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22050133_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor magnitude, keep or restore.
module ysyx_22050133_div_step
  import ysyx_22050133_divider_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_bit_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The shifted remainder can reach 2*|divisor|-1, so the trial needs one extra bit.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_o     = ~diff[XLEN];
    rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/ysyx_22050133_divider.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU and W forms): one quotient bit
// per cycle, with divide-by-zero and signed overflow resolved in one cycle.
module ysyx_22050133_divider
  import ysyx_22050133_divider_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            div_valid,
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             special_q, special_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             divw_q, divw_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  prem_q, prem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  quotient_q, quotient_d;
  logic [XLEN-1:0]  remainder_q, remainder_d;

  logic [XLEN-1:0]  a_ext, b_ext, a_abs, b_abs, a_w;
  logic             sa, sb, dvs_zero, ovf;
  logic [XLEN-1:0]  step_rem, quo_next;
  logic             step_q;

  function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] v,
                                            input logic neg, input logic w);
    logic [XLEN-1:0] t;
    t = neg ? -v : v;
    return w ? sext32(t[31:0]) : t;
  endfunction

  ysyx_22050133_div_step u_step (
    .rem_i     (prem_q),
    .dvd_bit_i (dvd_q[XLEN-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Operand preparation at the effective width
  always_comb begin
    a_w   = sext32(dividend[31:0]);
    a_ext = divw ? (div_signed ? a_w : {{(XLEN-32){1'b0}}, dividend[31:0]}) : dividend;
    b_ext = divw ? (div_signed ? sext32(divisor[31:0])
                               : {{(XLEN-32){1'b0}}, divisor[31:0]}) : divisor;
    sa    = div_signed & a_ext[XLEN-1];
    sb    = div_signed & b_ext[XLEN-1];
    a_abs = sa ? -a_ext : a_ext;
    b_abs = sb ? -b_ext : b_ext;
    dvs_zero = (b_ext == '0);
    ovf   = div_signed & (b_ext == '1) &
            (divw ? (dividend[31:0] == 32'h8000_0000)
                  : (dividend == {1'b1, {(XLEN-1){1'b0}}}));
    quo_next = {quo_q[XLEN-2:0], step_q};
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    last_d      = last_q;
    special_d   = special_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    divw_d      = divw_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    out_valid_d = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      DIV_IDLE: begin
        if (div_valid && !flush) begin
          state_d   = DIV_BUSY;
          count_d   = '0;
          last_d    = divw ? CNT_W'(ITER_32 - 1) : CNT_W'(ITER_64 - 1);
          special_d = dvs_zero | ovf;
          negq_d    = sa ^ sb;
          negr_d    = sa;
          divw_d    = divw;
          // W dividends are pre-aligned so the MSB-first shift starts at bit 31
          dvd_d     = divw ? {a_abs[31:0], 32'b0} : a_abs;
          dvs_d     = b_abs;
          if (dvs_zero) begin
            quo_d  = '1;
            prem_d = divw ? a_w : dividend;
          end else if (ovf) begin
            quo_d  = divw ? a_w : dividend;
            prem_d = '0;
          end else begin
            quo_d  = '0;
            prem_d = '0;
          end
        end
      end
      DIV_BUSY: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else if (special_q) begin
          state_d     = DIV_IDLE;
          out_valid_d = 1'b1;
          quotient_d  = quo_q;
          remainder_d = prem_q;
        end else begin
          dvd_d   = {dvd_q[XLEN-2:0], 1'b0};
          prem_d  = step_rem;
          quo_d   = quo_next;
          count_d = count_q + 1'b1;
          if (count_q == last_q) begin
            state_d     = DIV_IDLE;
            out_valid_d = 1'b1;
            quotient_d  = fixup(quo_next, negq_q, divw_q);
            remainder_d = fixup(step_rem, negr_q, divw_q);
          end
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      last_q      <= '0;
      special_q   <= 1'b0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      divw_q      <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      special_q   <= special_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      divw_q      <= divw_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign div_ready = (state_q == DIV_IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_22050133_divider.sv
// Bench for the iterative divider: directed table, handshake corner cases,
// and random operations against an arithmetic reference model.
module tb_ysyx_22050133_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        divw = 1'b0;
  logic        div_signed = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        div_ready;
  logic        out_valid;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ysyx_22050133_divider dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .div_valid  (div_valid),
    .divw       (divw),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_ready  (div_ready),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        w;
    logic        s;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the divider idle; returns at the negedge of cycle 1.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w, input logic s);
    dividend = a; divisor = b; divw = w; div_signed = s; div_valid = 1'b1;
    chk("accept_ready", {63'b0, div_ready}, 64'd1);
    @(negedge clk);
    div_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (out_valid) begin
        lat = c;
        return;
      end
      if (div_ready) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic w, input logic s, input logic [63:0] eq,
                           input logic [63:0] er, input int elat);
    int lat;
    bit bok;
    issue(a, b, w, s);
    wait_done(lat, bok);
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_ready_low_while_busy"}, {63'b0, bok}, 64'd1);
    @(negedge clk);
    chk({tag, "_single_pulse"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_result_held"}, quotient, eq);
  endtask

  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic w,
                       input logic s, output logic [63:0] q, output logic [63:0] r,
                       output int lat);
    logic [31:0] a32, b32, q32, r32;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      lat = 33;
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32; lat = 2;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0; lat = 2;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      lat = 65;
      if (b == 64'd0) begin
        q = '1; r = a; lat = 2;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0; lat = 2;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endtask

  task automatic expect_quiet(input string tag, input int ncyc);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk(tag, {63'b0, seen}, 64'd0);
  endtask

  initial begin
    int lat;
    bit bok;
    logic [63:0] ra, rb, eq, er, prev_q;
    logic rw, rs;
    int elat, mode;

    tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    tbl[1]  = '{64'd100, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 2};
    tbl[2]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 2};
    tbl[3]  = '{64'h1234_5678_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33};
    tbl[4]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 2};
    tbl[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 64'd0, 65};
    tbl[6]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65};
    tbl[7]  = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 2};
    tbl[8]  = '{64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    tbl[9]  = '{64'h0000_0000_FFFF_FFFF, 64'h10, 1'b1, 1'b0, 64'h0000_0000_0FFF_FFFF, 64'hF, 33};
    tbl[10] = '{64'hDEAD_BEEF_0000_0064, 64'h0000_0001_FFFF_FFF6, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 64'd0, 33};
    tbl[11] = '{64'h0000_0005_8000_0001, 64'h0000_0007_0000_0000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 2};
    tbl[12] = '{64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    tbl[13] = '{64'h0000_0000_8000_0005, 64'd2, 1'b1, 1'b0, 64'h0000_0000_4000_0002, 64'd1, 33};

    // Reset state
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_quotient", quotient, 64'd0);
    chk("reset_remainder", remainder, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", {63'b0, div_ready}, 64'd1);

    for (int i = 0; i < 14; i++) begin
      run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].s,
                tbl[i].q, tbl[i].r, tbl[i].lat);
    end

    // Flush while busy: aborted op never completes, results untouched
    prev_q = quotient;
    issue(64'd1000, 64'd7, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready_next", {63'b0, div_ready}, 64'd1);
    expect_quiet("flush_no_out_valid", 70);
    chk("flush_quotient_kept", quotient, prev_q);
    run_check("after_flush", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 65);

    // Flush in idle alongside a request: not accepted
    dividend = 64'd50; divisor = 64'd5; divw = 1'b0; div_signed = 1'b0;
    div_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    div_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_ready", {63'b0, div_ready}, 64'd1);
    expect_quiet("idle_flush_no_op", 5);

    // Back-to-back: second request accepted in the first op's out_valid cycle
    issue(64'd7, 64'd2, 1'b0, 1'b0);
    wait_done(lat, bok);
    chk("b2b_first_latency", 64'(lat), 64'd65);
    chk("b2b_first_quotient", quotient, 64'd3);
    chk("b2b_first_remainder", remainder, 64'd1);
    dividend = 64'd20; divisor = 64'd6; div_valid = 1'b1;
    chk("b2b_ready_in_done_cycle", {63'b0, div_ready}, 64'd1);
    @(negedge clk);
    div_valid = 1'b0;
    wait_done(lat, bok);
    chk("b2b_second_latency", 64'(lat), 64'd65);
    chk("b2b_second_quotient", quotient, 64'd3);
    chk("b2b_second_remainder", remainder, 64'd2);
    @(negedge clk);

    // Reset mid-operation
    issue(64'hFFFF, 64'd3, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_quotient", quotient, 64'd0);
    chk("midrst_remainder", remainder, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", {63'b0, div_ready}, 64'd1);
    expect_quiet("midrst_no_out_valid", 70);

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      rw = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      if (mode == 0) rb = {$urandom, 32'd0} & {64{~rw}};
      if (mode == 1) rb = {$urandom, 32'hFFFF_FFFF} | {64{~rw}};
      if (mode == 2) begin
        ra = rw ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        rb = rw ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
      end
      model(ra, rb, rw, rs, eq, er, elat);
      run_check("rand", ra, rb, rw, rs, eq, er, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
